// File: rtl/data_sync_hs.sv
// Destination-domain bus synchronizer. A flop chain synchronizes the enable, an edge
// detector qualifies a capture of the held source bus, and a valid/ready stage holds it.
module data_sync_hs #(
  parameter int unsigned           BUS_WIDTH  = 8,
  parameter int unsigned           NUM_STAGES = 2,
  parameter bit                    MODE       = 1'b0,
  parameter logic [BUS_WIDTH-1:0]  RESET_VAL  = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  input  logic                 ready,
  input  logic                 clr_ovr,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse,
  output logic                 valid,
  output logic                 ack,
  output logic                 overrun
);

  if (NUM_STAGES < 2) begin : g_bad_stages
    $error("data_sync_hs: NUM_STAGES must be at least 2");
  end

  logic [NUM_STAGES-1:0] r_sync;
  logic                  r_prev;
  logic [BUS_WIDTH-1:0]  r_bus;
  logic                  r_pulse;
  logic                  r_valid;
  logic                  r_ovr;

  logic                  w_evt;
  logic                  w_capture;
  logic                  w_drop;
  logic [BUS_WIDTH-1:0]  w_bus_nxt;
  logic                  w_valid_nxt;
  logic                  w_ovr_nxt;

  // Toggle mode treats either edge of the synchronized enable as a new event.
  assign w_evt = MODE ? (r_sync[NUM_STAGES-1] ^ r_prev)
                      : (r_sync[NUM_STAGES-1] & ~r_prev);

  assign w_capture = w_evt & (~r_valid | ready);
  assign w_drop    = w_evt & r_valid & ~ready;

  always_comb begin
    w_bus_nxt   = r_bus;
    w_valid_nxt = r_valid;
    w_ovr_nxt   = r_ovr;
    if (w_capture) begin
      w_bus_nxt   = unsync_bus;
      w_valid_nxt = 1'b1;
    end else if (r_valid && ready) begin
      w_valid_nxt = 1'b0;
    end
    // A drop in the same cycle as a clear must still be reported.
    if (w_drop) begin
      w_ovr_nxt = 1'b1;
    end else if (clr_ovr) begin
      w_ovr_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_bus   <= RESET_VAL;
      r_pulse <= 1'b0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[NUM_STAGES-2:0], bus_enable};
      r_prev  <= r_sync[NUM_STAGES-1];
      r_bus   <= w_bus_nxt;
      r_pulse <= w_capture;
      r_valid <= w_valid_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  assign sync_bus     = r_bus;
  assign enable_pulse = r_pulse;
  assign valid        = r_valid;
  assign ack          = r_prev;
  assign overrun      = r_ovr;

endmodule

// File: tb/tb_data_sync_hs.sv
// Bench for data_sync_hs: a level-mode 2-stage and a toggle-mode 3-stage instance share
// stimulus and are compared every cycle against an enable-history reference model.
module tb_data_sync_hs;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] unsync_bus = 8'h00;
  logic       bus_enable = 1'b0;
  logic       ready = 1'b0;
  logic       clr_ovr = 1'b0;

  logic [7:0] sb0, sb1;
  logic       pl0, pl1, vl0, vl1, ak0, ak1, ov0, ov1;

  int n_checks = 0;
  int n_errors = 0;

  localparam int       NS[2]  = '{2, 3};
  localparam bit       MD[2]  = '{1'b0, 1'b1};
  localparam bit [7:0] RV[2]  = '{8'h00, 8'h5A};

  always #5 clk = ~clk;

  data_sync_hs #(.BUS_WIDTH(8), .NUM_STAGES(2), .MODE(1'b0), .RESET_VAL(8'h00)) dut0 (
    .CLK(clk), .RST(RST), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .ready(ready), .clr_ovr(clr_ovr), .sync_bus(sb0), .enable_pulse(pl0),
    .valid(vl0), .ack(ak0), .overrun(ov0));

  data_sync_hs #(.BUS_WIDTH(8), .NUM_STAGES(3), .MODE(1'b1), .RESET_VAL(8'h5A)) dut1 (
    .CLK(clk), .RST(RST), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .ready(ready), .clr_ovr(clr_ovr), .sync_bus(sb1), .enable_pulse(pl1),
    .valid(vl1), .ack(ak1), .overrun(ov1));

  // Reference model: every enable sample since reset release is logged; an event at edge t
  // is decided by the samples taken N and N+1 edges earlier.
  bit       en_log[$];
  bit [7:0] m_bus[2];
  bit       m_pulse[2], m_valid[2], m_ack[2], m_ovr[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    en_log.delete();
    for (int d = 0; d < 2; d++) begin
      m_bus[d]   = RV[d];
      m_pulse[d] = 1'b0;
      m_valid[d] = 1'b0;
      m_ack[d]   = 1'b0;
      m_ovr[d]   = 1'b0;
    end
  endtask

  task automatic model_edge();
    int t;
    bit cur, old, evt, drop;
    t = en_log.size();
    for (int d = 0; d < 2; d++) begin
      cur  = (t >= NS[d])     ? en_log[t-NS[d]]   : 1'b0;
      old  = (t >= NS[d] + 1) ? en_log[t-NS[d]-1] : 1'b0;
      evt  = MD[d] ? (cur != old) : (cur && !old);
      drop = evt && m_valid[d] && !ready;
      m_ack[d] = cur;
      if (evt && (!m_valid[d] || ready)) begin
        m_bus[d]   = unsync_bus;
        m_pulse[d] = 1'b1;
        m_valid[d] = 1'b1;
      end else begin
        m_pulse[d] = 1'b0;
        if (m_valid[d] && ready) m_valid[d] = 1'b0;
      end
      m_ovr[d] = drop || (m_ovr[d] && !clr_ovr);
    end
    en_log.push_back(bus_enable);
  endtask

  task automatic compare_all();
    chk("d0_bus",   sb0, m_bus[0]);
    chk("d0_pulse", pl0, m_pulse[0]);
    chk("d0_valid", vl0, m_valid[0]);
    chk("d0_ack",   ak0, m_ack[0]);
    chk("d0_ovr",   ov0, m_ovr[0]);
    chk("d1_bus",   sb1, m_bus[1]);
    chk("d1_pulse", pl1, m_pulse[1]);
    chk("d1_valid", vl1, m_valid[1]);
    chk("d1_ack",   ak1, m_ack[1]);
    chk("d1_ovr",   ov1, m_ovr[1]);
  endtask

  // Inputs change only at the falling edge; the model samples them at the rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (RST) model_edge();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic async_reset(input int hold);
    #2 RST = 1'b0;
    model_reset();
    #1 compare_all();
    step(hold);
    RST = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 RST = 1'b0;
    #2;
    compare_all();
    chk("rst_d0_bus", sb0, 32'h00);
    chk("rst_d1_bus", sb1, 32'h5A);
    step(3);
    RST = 1'b1;
    step(4);

    // Level mode, ready high: single pulse on the third edge.
    ready = 1'b1; bus_enable = 1'b1; unsync_bus = 8'hA5;
    step(3);
    chk("t1_pulse", pl0, 1); chk("t1_bus", sb0, 32'hA5); chk("t1_valid", vl0, 1);
    step(1);
    chk("t1_pulse_off", pl0, 0); chk("t1_valid_off", vl0, 0);

    // Enable held high, data changes after the pulse: no second capture.
    bus_enable = 1'b0; step(6);
    bus_enable = 1'b1; unsync_bus = 8'h11; step(3);
    chk("t2_pulse", pl0, 1); chk("t2_bus", sb0, 32'h11);
    unsync_bus = 8'h22; step(20);
    chk("t2_hold", sb0, 32'h11);

    // Toggle mode, three stages: each edge arrives four edges later.
    bus_enable = 1'b0; step(8);
    bus_enable = 1'b1; unsync_bus = 8'h01; step(4);
    chk("t3_pulse_a", pl1, 1); chk("t3_bus_a", sb1, 32'h01);
    step(6);
    bus_enable = 1'b0; unsync_bus = 8'h02; step(4);
    chk("t3_pulse_b", pl1, 1); chk("t3_bus_b", sb1, 32'h02);

    // Consumer stalled: second event is dropped and flagged.
    ready = 1'b0; step(6);
    bus_enable = 1'b1; unsync_bus = 8'h33; step(6);
    bus_enable = 1'b0; step(4);
    bus_enable = 1'b1; unsync_bus = 8'h44; step(6);
    chk("t4_bus", sb0, 32'h33); chk("t4_valid", vl0, 1); chk("t4_ovr", ov0, 1);
    clr_ovr = 1'b1; step(1); clr_ovr = 1'b0;
    chk("t4_clr", ov0, 0);
    ready = 1'b1; step(1);
    chk("t4_drain", vl0, 0);

    // Consume and capture in the same cycle.
    ready = 1'b0; bus_enable = 1'b0; step(5);
    bus_enable = 1'b1; unsync_bus = 8'h66; step(5);
    bus_enable = 1'b0; step(4);
    bus_enable = 1'b1; unsync_bus = 8'h55; step(2);
    ready = 1'b1; step(1);
    chk("t5_bus", sb0, 32'h55); chk("t5_valid", vl0, 1);
    chk("t5_pulse", pl0, 1); chk("t5_ovr", ov0, 0);
    step(1);
    chk("t5_drain", vl0, 0);

    // Reset in mid-chain with enable still high afterwards.
    bus_enable = 1'b0; step(5);
    bus_enable = 1'b1; unsync_bus = 8'h77; step(1);
    async_reset(2);
    chk("t6_rst_bus0", sb0, 32'h00); chk("t6_rst_bus1", sb1, 32'h5A);
    step(3);
    chk("t6_pulse", pl0, 1); chk("t6_bus", sb0, 32'h77);
    step(1);
    chk("t6_once", pl0, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) bus_enable = ~bus_enable;
      unsync_bus = 8'($urandom);
      ready      = ($urandom_range(0, 3) != 0);
      clr_ovr    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) async_reset(2);
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
